// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 S-RAM clients: sizes, RAM-controller mode codes
// and the PRGA decryptor state encoding.
package rc4_pkg;

    localparam int RAM_WIDTH_DEF = 8;
    localparam int S_SIZE        = 256;

    localparam logic [2:0] MODE_INIT    = 3'b001;
    localparam logic [2:0] MODE_SHUFFLE = 3'b010;
    localparam logic [2:0] MODE_DECRYPT = 3'b011;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_RD_I = 4'd1,
        ST_RD_J = 4'd2,
        ST_WR_I = 4'd3,
        ST_WR_J = 4'd4,
        ST_RD_F = 4'd5,
        ST_WR_D = 4'd6,
        ST_DONE = 4'd7
    } prga_state_e;

    function automatic logic is_read_state(input prga_state_e st);
        return (st == ST_RD_I) || (st == ST_RD_J) || (st == ST_RD_F);
    endfunction

endpackage

// File: rtl/rc4_prga_decryptor_ram_read_wait.sv
// Two-cycle read wait for the latency-2 synchronous memories: data_valid marks
// the second cycle of a held address, whose closing edge samples the data.
module ram_read_wait (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic data_valid
);

    logic cnt_r;

    // Count the cycles an address has been held; restart after each completed read
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= 1'b0;
        end else if (!enable || cnt_r) begin
            cnt_r <= 1'b0;
        end else begin
            cnt_r <= 1'b1;
        end
    end

    assign data_valid = enable & cnt_r;

endmodule

// File: rtl/rc4_prga_decryptor.sv
// RC4 keystream generator: walks the shuffled S RAM, XORs each keystream byte
// with the encrypted ROM byte and writes the plaintext to the decrypted RAM.
module rc4_prga_decryptor
    import rc4_pkg::*;
#(
    parameter int RAM_WIDTH      = RAM_WIDTH_DEF,
    parameter int MSG_LENGTH     = 32,
    parameter int MSG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    output logic                      finished,
    input  logic [RAM_WIDTH-1:0]      ram_out,
    output logic                      write_enable,
    output logic [RAM_WIDTH-1:0]      ram_in,
    output logic [RAM_WIDTH-1:0]      address,
    input  logic [RAM_WIDTH-1:0]      enc_data,
    output logic [MSG_ADDR_WIDTH-1:0] enc_address,
    output logic                      dec_write_enable,
    output logic [RAM_WIDTH-1:0]      dec_data,
    output logic [MSG_ADDR_WIDTH-1:0] dec_address
);

    localparam logic [MSG_ADDR_WIDTH-1:0] K_LAST = MSG_ADDR_WIDTH'(MSG_LENGTH - 1);

    prga_state_e               state_r;
    prga_state_e               state_s;
    logic [RAM_WIDTH-1:0]      i_r;
    logic [RAM_WIDTH-1:0]      j_r;
    logic [RAM_WIDTH-1:0]      si_r;
    logic [RAM_WIDTH-1:0]      sj_r;
    logic [RAM_WIDTH-1:0]      f_r;
    logic [RAM_WIDTH-1:0]      enc_q_r;
    logic [MSG_ADDR_WIDTH-1:0] k_r;
    logic                      rd_en_s;
    logic                      rd_valid_s;
    logic                      last_s;

    assign rd_en_s = is_read_state(state_r);
    assign last_s  = (k_r == K_LAST);

    ram_read_wait u_read_wait (
        .clk        (clk),
        .reset      (reset),
        .enable     (rd_en_s),
        .data_valid (rd_valid_s)
    );

    // State register plus index/data latches; reset abandons any byte in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            i_r     <= '0;
            j_r     <= '0;
            k_r     <= '0;
            si_r    <= '0;
            sj_r    <= '0;
            f_r     <= '0;
            enc_q_r <= '0;
        end else begin
            state_r <= state_s;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        i_r <= RAM_WIDTH'(1);
                        j_r <= '0;
                        k_r <= '0;
                    end
                end
                ST_RD_I: begin
                    if (rd_valid_s) begin
                        si_r <= ram_out;
                        j_r  <= j_r + ram_out;
                    end
                end
                ST_RD_J: begin
                    if (rd_valid_s) begin
                        sj_r <= ram_out;
                    end
                end
                ST_RD_F: begin
                    if (rd_valid_s) begin
                        f_r     <= ram_out;
                        enc_q_r <= enc_data;
                    end
                end
                ST_WR_D: begin
                    if (!last_s) begin
                        k_r <= k_r + MSG_ADDR_WIDTH'(1);
                        i_r <= i_r + RAM_WIDTH'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state sequencing: 9 cycles per message byte
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: if (start)      state_s = ST_RD_I; else state_s = ST_IDLE;
            ST_RD_I: if (rd_valid_s) state_s = ST_RD_J; else state_s = ST_RD_I;
            ST_RD_J: if (rd_valid_s) state_s = ST_WR_I; else state_s = ST_RD_J;
            ST_WR_I: state_s = ST_WR_J;
            ST_WR_J: state_s = ST_RD_F;
            ST_RD_F: if (rd_valid_s) state_s = ST_WR_D; else state_s = ST_RD_F;
            ST_WR_D: if (last_s)     state_s = ST_DONE; else state_s = ST_RD_I;
            ST_DONE: if (start)      state_s = ST_DONE; else state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Output decode from state and latched registers only
    always_comb begin
        address          = '0;
        ram_in           = '0;
        write_enable     = 1'b0;
        dec_write_enable = 1'b0;
        dec_data         = '0;
        dec_address      = '0;
        case (state_r)
            ST_RD_I: address = i_r;
            ST_RD_J: address = j_r;
            ST_WR_I: begin
                address      = i_r;
                ram_in       = sj_r;
                write_enable = 1'b1;
            end
            ST_WR_J: begin
                address      = j_r;
                ram_in       = si_r;
                write_enable = 1'b1;
            end
            ST_RD_F: address = si_r + sj_r;
            ST_WR_D: begin
                dec_address      = k_r;
                dec_data         = f_r ^ enc_q_r;
                dec_write_enable = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign enc_address = k_r;
    assign finished    = (state_r == ST_DONE);

endmodule

// File: doc/rc4_prga_decryptor.md
Name: rc4_prga_decryptor

Overview:
- RC4 pseudo-random generation stage, directly downstream of the key-schedule shuffler.
- Runs after the shuffler leaves S[0..255] permuted in the shared S RAM. The RAM controller grants this block the S RAM port under its own mode code.
- Per message byte: updates i/j, swaps S[i]/S[j], reads keystream byte f, reads one encrypted byte from ROM, writes f XOR enc to the decrypted-message RAM.
- Uses the same start/finished device handshake as the other S-RAM clients.

Parameters:
- RAM_WIDTH, 8, data and S-RAM address width.
- MSG_LENGTH, 32, number of message bytes processed (1..1024).
- MSG_ADDR_WIDTH, 5, address width of the encrypted ROM and decrypted RAM; at least clog2(MSG_LENGTH).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- start  in  1  begin request, level, sampled only in IDLE.
- finished  out  1  high in DONE.
- ram_out  in  RAM_WIDTH  S RAM read data.
- write_enable  out  1  S RAM write strobe.
- ram_in  out  RAM_WIDTH  S RAM write data.
- address  out  RAM_WIDTH  S RAM address.
- enc_data  in  RAM_WIDTH  encrypted ROM read data.
- enc_address  out  MSG_ADDR_WIDTH  encrypted ROM address.
- dec_write_enable  out  1  decrypted RAM write strobe.
- dec_data  out  RAM_WIDTH  decrypted byte.
- dec_address  out  MSG_ADDR_WIDTH  decrypted RAM address.

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE.
  - i, j, k, si, sj, f, enc_q = 0.
  - All outputs 0, including write_enable, dec_write_enable and finished.
  - Reset mid-operation aborts immediately. Memory contents already written stay as they are; no further writes occur.
- Memory timing: S RAM and ROM are synchronous with read latency 2. The address is held stable for two cycles and data is sampled on the edge that ends the second cycle. Writes commit on the edge ending the single cycle the strobe is high.
- States and S-RAM actions (all indices mod 256, 8-bit wrap):
  - IDLE: if start, then i <= 1, j <= 0, k <= 0, go to RD_I.
  - RD_I (2 cycles): address = i; latch si; j <= j + si; go to RD_J.
  - RD_J (2 cycles): address = j; latch sj; go to WR_I.
  - WR_I (1 cycle): address = i, ram_in = sj, write_enable = 1.
  - WR_J (1 cycle): address = j, ram_in = si, write_enable = 1.
  - RD_F (2 cycles): address = si + sj (8-bit wrap, pre-swap values); latch f = ram_out and enc_q = enc_data.
  - WR_D (1 cycle): dec_address = k, dec_data = f ^ enc_q, dec_write_enable = 1.
    - If k == MSG_LENGTH-1, go to DONE.
    - Otherwise k <= k+1, i <= i+1, go to RD_I.
  - DONE: finished = 1. Stay while start is high; return to IDLE when start is low.
- Exactly 9 cycles per byte. The first RD_I cycle is the cycle after start is sampled. finished first goes high 9*MSG_LENGTH+1 cycles after the start-sampling edge.
- enc_address = k, held for the whole byte.
- write_enable is high only in WR_I and WR_J. dec_write_enable is high only in WR_D. The two are never high in the same cycle.
- i == j: both writes store the same value, so S is unchanged. This is legal and requires no special case.
- i wraps 255 -> 0 for MSG_LENGTH > 255.
- start high in any state other than IDLE or DONE is ignored.
- Outputs are registered or decoded from state only. There is no combinational path from ram_out or enc_data to any output except through latched registers.

Decomposition:
- Shared package rc4_pkg holds:
  - RAM_WIDTH default.
  - S size constant 256.
  - Controller mode codes (init 3'b001, shuffle 3'b010, decrypt 3'b011).
  - typedef enum for this block's state, logic [3:0].
- The 2-cycle read wait is a shared sub-module ram_read_wait: a counter that pulses data_valid on the second cycle of a held address. The shuffler reuses it.

Test Plan:
- Identity S preload, enc all 0x00, MSG_LENGTH = 3, start held -> dec[0..2] = 0x02, 0x05, 0x07. Final S[2] = 3, S[3] = 5, S[5] = 2.
- Same preload, enc = 0xFF, 0x00, 0xA5 -> dec = 0xFD, 0x05, 0xA2. finished rises exactly 28 cycles after the start edge.
- Handshake: hold start for 10 cycles after finished -> finished stays high, no writes occur. Drop start -> IDLE next cycle, finished = 0.
- Reset asserted in RD_J of byte 1 -> next cycle all outputs 0 and state IDLE. Bytes at k ≥ 1 are never written. A fresh start reruns from i = 1, j = 0.
- Random permutation S, random enc, MSG_LENGTH = 300 -> dec matches a software RC4 PRGA model byte-for-byte, including across the i wrap at byte 256.
- Protocol checker over all runs:
  - write_enable and dec_write_enable never both high.
  - address stable for both cycles of every read state.
